// File: rtl/branch_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : branch_hazard_controller
// Brief   : Condition-unit sequencer: flag-hazard stall, taken-branch flush, stats.
// Revision: 1.0
// ============================================================================
module branch_hazard_controller #(
  parameter int FLAG_LAT     = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_id,
  input  logic             branch_id,
  input  logic [2:0]       cond_id,
  input  logic             pc_src,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_if_id,
  output logic             flag_write,
  output logic             branch_inst,
  output logic [2:0]       cond_ex,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int HZ_W = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;
  localparam int FL_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;

  localparam logic [1:0] c_RUN   = 2'd0;
  localparam logic [1:0] c_HAZ   = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;

  localparam logic [HZ_W-1:0]  c_HZ_LOAD = HZ_W'(FLAG_LAT - 1);
  localparam logic [FL_W-1:0]  c_FL_LOAD = FL_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [HZ_W-1:0] r_hz_cnt;
  logic [FL_W-1:0] r_fl_cnt;
  logic [FL_W-1:0] w_fl_nxt;

  logic w_taken;
  logic w_needs_flags;
  logic w_hz;
  logic w_in_flush;
  logic w_issue;
  logic w_stall;

  assign w_taken       = branch_inst & pc_src;
  assign w_needs_flags = branch_id & (cond_id != 3'b110) & (cond_id != 3'b111);
  assign w_hz          = w_needs_flags & (r_hz_cnt != '0);
  assign w_in_flush    = (r_state == c_FLUSH);
  assign w_issue       = ~w_hz & ~w_taken & ~w_in_flush;
  assign w_stall       = w_hz & ~w_taken & ~w_in_flush;

  assign stall_if    = w_stall;
  assign stall_id    = w_stall;
  assign flush_if_id = w_taken | w_in_flush;

  // Priority: taken > flush in progress > hazard > normal issue.
  always_comb begin
    w_state_nxt = r_state;
    w_fl_nxt    = r_fl_cnt;
    if (w_taken) begin
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = c_FLUSH;
        w_fl_nxt    = c_FL_LOAD;
      end else begin
        w_state_nxt = c_RUN;
      end
    end else if (w_in_flush) begin
      if (r_fl_cnt == '0) begin
        w_state_nxt = c_RUN;
      end else begin
        w_fl_nxt = r_fl_cnt - FL_W'(1);
      end
    end else if (w_hz) begin
      w_state_nxt = c_HAZ;
    end else begin
      w_state_nxt = c_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_RUN;
      r_fl_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_fl_cnt <= w_fl_nxt;
    end
  end

  // Only an issued CMP arms the flag-latency window; discarded ones do not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hz_cnt <= '0;
    end else if (w_issue & cmp_id) begin
      r_hz_cnt <= c_HZ_LOAD;
    end else if (r_hz_cnt != '0) begin
      r_hz_cnt <= r_hz_cnt - HZ_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_write  <= 1'b0;
      branch_inst <= 1'b0;
      cond_ex     <= 3'b000;
    end else if (w_issue) begin
      flag_write  <= cmp_id;
      branch_inst <= branch_id;
      cond_ex     <= cond_id;
    end else begin
      flag_write  <= 1'b0;
      branch_inst <= 1'b0;
      cond_ex     <= 3'b000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_taken && (taken_cnt != c_CNT_MAX)) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
      if (w_stall && (stall_cnt != c_CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_hazard_controller
// Brief   : Directed + random bench with a cycle-timestamp reference model.
// Revision: 1.0
// ============================================================================
module tb_branch_hazard_controller;

  localparam int FLAG_LAT     = 2;
  localparam int FLUSH_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmp_id, branch_id, pc_src;
  logic [2:0] cond_id;

  logic        a_stall_if, a_stall_id, a_flush, a_fw, a_bi;
  logic [2:0]  a_cond;
  logic [15:0] a_taken_cnt, a_stall_cnt;
  logic        b_stall_if, b_stall_id, b_flush, b_fw, b_bi;
  logic [2:0]  b_cond;
  logic [1:0]  b_taken_cnt, b_stall_cnt;

  branch_hazard_controller u_dut (
    .clk(clk), .rst(rst), .cmp_id(cmp_id), .branch_id(branch_id), .cond_id(cond_id),
    .pc_src(pc_src), .stall_if(a_stall_if), .stall_id(a_stall_id), .flush_if_id(a_flush),
    .flag_write(a_fw), .branch_inst(a_bi), .cond_ex(a_cond),
    .taken_cnt(a_taken_cnt), .stall_cnt(a_stall_cnt)
  );

  branch_hazard_controller #(.CNT_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .cmp_id(cmp_id), .branch_id(branch_id), .cond_id(cond_id),
    .pc_src(pc_src), .stall_if(b_stall_if), .stall_id(b_stall_id), .flush_if_id(b_flush),
    .flag_write(b_fw), .branch_inst(b_bi), .cond_ex(b_cond),
    .taken_cnt(b_taken_cnt), .stall_cnt(b_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: timestamps of the last CMP entering EX and the end of the flush window.
  int         m_t;
  int         m_last_cmp_ex;
  int         m_flush_end;
  int         m_taken;
  int         m_stall;
  logic       m_fw, m_bi;
  logic [2:0] m_cond;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, m_t);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    m_last_cmp_ex = m_t - 100;
    m_flush_end   = m_t;
    m_taken       = 0;
    m_stall       = 0;
    m_fw          = 1'b0;
    m_bi          = 1'b0;
    m_cond        = 3'b000;
  endtask

  task automatic check_and_advance();
    logic taken, nf, hz, infl, stall, issue;
    taken = m_bi & pc_src;
    nf    = branch_id && (cond_id != 3'd6) && (cond_id != 3'd7);
    hz    = nf && ((m_t + 1 - m_last_cmp_ex) < FLAG_LAT);
    infl  = (m_t < m_flush_end);
    stall = hz & ~taken & ~infl;
    issue = ~hz & ~taken & ~infl;

    check("stall_if", 32'(a_stall_if), 32'(stall));
    check("stall_id", 32'(a_stall_id), 32'(stall));
    check("flush_if_id", 32'(a_flush), 32'(taken | infl));
    check("flag_write", 32'(a_fw), 32'(m_fw));
    check("branch_inst", 32'(a_bi), 32'(m_bi));
    check("cond_ex", 32'(a_cond), 32'(m_cond));
    check("taken_cnt", 32'(a_taken_cnt), 32'(sat(m_taken, 65535)));
    check("stall_cnt", 32'(a_stall_cnt), 32'(sat(m_stall, 65535)));
    check("small_stall_if", 32'(b_stall_if), 32'(stall));
    check("small_flush", 32'(b_flush), 32'(taken | infl));
    check("small_taken_cnt", 32'(b_taken_cnt), 32'(sat(m_taken, 3)));
    check("small_stall_cnt", 32'(b_stall_cnt), 32'(sat(m_stall, 3)));

    if (taken) begin
      m_taken++;
      m_flush_end = m_t + FLUSH_CYCLES;
    end
    if (stall) m_stall++;
    if (issue) begin
      m_fw   = cmp_id;
      m_bi   = branch_id;
      m_cond = cond_id;
      if (cmp_id) m_last_cmp_ex = m_t + 1;
    end else begin
      m_fw   = 1'b0;
      m_bi   = 1'b0;
      m_cond = 3'b000;
    end
    m_t++;
  endtask

  task automatic step(input logic c, input logic b, input logic [2:0] cd, input logic p);
    cmp_id    = c;
    branch_id = b;
    cond_id   = cd;
    pc_src    = p;
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {a_stall_if, a_stall_id, a_flush, a_fw, a_bi, a_cond, a_taken_cnt, a_stall_cnt}, 32'd0);
    check({tag, "_b"}, 32'({b_stall_if, b_stall_id, b_flush, b_fw, b_bi, b_cond, b_taken_cnt, b_stall_cnt}), 32'd0);
  endtask

  // Called just after a rising edge: asserts reset between edges.
  task automatic async_reset();
    rst = 1'b1;
    #2;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    cmp_id = 1'b0; branch_id = 1'b0; cond_id = 3'b000; pc_src = 1'b0;
    m_t = 0;
    model_reset();
    @(posedge clk);
    #1;
    cmp_id = 1'b1; branch_id = 1'b1; pc_src = 1'b1;
    #1;
    check_all_zero("reset");
    cmp_id = 1'b0; branch_id = 1'b0; pc_src = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // CMP then dependent conditional branch: one stall cycle.
    step(1, 0, 3'd0, 0);
    step(0, 1, 3'd0, 0);
    step(0, 1, 3'd0, 0);
    step(0, 0, 3'd0, 0);
    check("dir_stall_cnt", 32'(a_stall_cnt), 32'd1);

    // Unconditional branch right after CMP: no stall.
    step(1, 0, 3'd0, 0);
    step(0, 1, 3'd7, 0);
    step(0, 0, 3'd0, 0);

    // Taken branch with CMP in ID: CMP discarded, two flush cycles.
    step(0, 1, 3'd7, 0);
    step(1, 0, 3'd0, 1);
    step(0, 0, 3'd0, 0);
    step(0, 0, 3'd0, 0);
    check("dir_taken_cnt", 32'(a_taken_cnt), 32'd1);

    // Taken branch while a hazard stall is pending in ID.
    step(1, 1, 3'd7, 0);
    step(0, 1, 3'd0, 1);
    step(0, 1, 3'd0, 0);
    step(0, 0, 3'd0, 0);

    // Asynchronous reset in the middle of a flush.
    step(0, 1, 3'd7, 0);
    step(0, 0, 3'd0, 1);
    check("pre_rst_flush", 32'(a_flush), 32'd1);
    async_reset();

    // Five taken branches saturate the 2-bit counters.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 3'd7, 0);
      step(0, 0, 3'd0, 1);
      step(0, 0, 3'd0, 0);
    end
    check("sat_small_taken", 32'(b_taken_cnt), 32'd3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4),
             3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_hazard_controller.md
Name: branch_hazard_controller

Overview:
- Sequences the condition unit in the pipelined hybrid ARM/MIPS core.
- Owns the ID→EX pipeline copies of the condition unit's controls: flag_write (enable1/FlagWrite), branch_inst (enable2/BranchInst) and cond_ex (CondFlag).
- Stalls a conditional branch in ID until the flags of the preceding CMP are visible.
- On a taken branch (PCSrc), squashes wrong-path instructions in IF/ID.
- Keeps taken-branch and stall statistics.

Parameters:
- FLAG_LAT, 2: cycles from a CMP entering EX until its flags are readable by a branch entering EX (≥1).
- FLUSH_CYCLES, 2: cycles flush_if_id stays high per taken branch (≥1).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmp_id  in  1  instruction in ID writes flags.
- branch_id  in  1  instruction in ID is a branch.
- cond_id  in  3  condition code of the ID instruction.
- pc_src  in  1  taken result from the condition unit for the branch currently in EX.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- flush_if_id  out  1  clear IF/ID (wrong path).
- flag_write  out  1  EX-stage flag register enable.
- branch_inst  out  1  EX-stage branch qualifier.
- cond_ex  out  3  EX-stage condition code.
- taken_cnt  out  CNT_W  taken branches since reset.
- stall_cnt  out  CNT_W  hazard-stall cycles since reset.

Behaviour:
- Reset (async, any state):
  - state=RUN, hz_cnt=0, fl_cnt=0.
  - flag_write=0, branch_inst=0, cond_ex=3'b000, taken_cnt=0, stall_cnt=0.
  - Combinational outputs evaluate to 0.
- States:
  - RUN: normal issue.
  - HAZ: branch held in ID.
  - FLUSH: squashing the wrong path.
- taken = branch_inst & pc_src (combinational, EX cycle).
- needs_flags = branch_id & (cond_id != 3'b110) & (cond_id != 3'b111). Codes 110 (never) and 111 (always) never stall.
- hz = needs_flags & (hz_cnt != 0).
- Issue:
  - issue = ~hz & ~taken & (state != FLUSH).
  - On issue, the next edge loads flag_write<=cmp_id, branch_inst<=branch_id, cond_ex<=cond_id.
  - Otherwise it loads a bubble: flag_write=0, branch_inst=0, cond_ex=000.
- hz_cnt:
  - When cmp_id issues, load FLAG_LAT-1.
  - Else if nonzero, decrement.
  - A branch entering EX k cycles after a CMP entered EX is legal iff k ≥ FLAG_LAT.
- Stall outputs: stall_if = stall_id = hz & ~taken & (state != FLUSH). Combinational.
- Flush output: flush_if_id = taken | (state == FLUSH). Combinational.
- Transitions:
  - RUN→HAZ when hz & ~taken.
  - HAZ→RUN when hz_cnt reaches 0. The branch issues in the first cycle with hz_cnt == 0.
  - Any state→FLUSH on taken when FLUSH_CYCLES > 1, with fl_cnt loaded FLUSH_CYCLES-2.
  - FLUSH→RUN after fl_cnt reaches 0, decrementing once per cycle. Total flush = FLUSH_CYCLES cycles including the taken cycle.
  - FLUSH_CYCLES = 1: taken stays in RUN.
- Priority: taken > flush in progress > hazard stall > issue.
  - A branch or CMP sitting in ID during a taken cycle or FLUSH is discarded: not issued, no hz_cnt load.
  - In FLUSH, flag_write, branch_inst and cond_ex are bubbles.
- Counters:
  - taken_cnt +1 per taken cycle.
  - stall_cnt +1 per cycle with stall_if = 1.
  - Both saturate at all-ones (no wrap).
- Reset mid-stall or mid-flush: returns to RUN immediately; pending hazard and flush are dropped.

Test Plan:
- Defaults throughout. CMP issues at cycle 0, conditional branch (cond=000) in ID at cycle 1.
  → stall_if=1 for cycle 1 only; branch_inst=1 at cycle 3; stall_cnt=1.
- Branch with cond=111 in ID immediately after a CMP. → No stall; branch_inst=1 next cycle.
- Branch in EX, pc_src=1, CMP in ID the same cycle.
  → flush_if_id=1 for 2 cycles; CMP discarded (flag_write stays 0); taken_cnt=1.
- Branch in EX with pc_src=1 while a hazard stall is active in ID. → stall_if=0; flush wins; state FLUSH then RUN.
- rst pulsed asynchronously mid-FLUSH. → All outputs 0 before the next clk edge; state RUN.
- CNT_W=2, 5 taken branches. → taken_cnt saturates at 3.
